// File: rtl/updn_ctrl_pkg.sv
// Shared definitions for the up/down count sequencer: FSM state encoding
// and direction constants used by the sequencer and its counter core.
package updn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/updn_counter_core.sv
// Modulo-(limit+1) up/down counter with a one-cycle registered wrap flag.
// load has priority over step; clr clears both count and wrap.
module updn_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  import updn_ctrl_pkg::*;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  // NOTE: sequential state uses nonblocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_count <= (mode == MODE_UP) ? '0 : limit;
      end else if (step) begin
        if (mode == MODE_UP) begin
          if (r_count == limit) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end else begin
          // limit == 0 lands here every step, so count stays 0 and wrap pulses
          if (r_count == '0) begin
            r_count <= limit;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= r_count - WIDTH'(1);
          end
        end
      end
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: rtl/updn_count_sequencer.sv
// Command-driven sequencer: accepts {mode, limit, steps}, loads the counter
// core, issues the requested number of steps, then pulses done.
module updn_count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [WIDTH-1:0]   cmd_limit,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               wrap,
  output logic               done
);
  import updn_ctrl_pkg::*;

  state_t             r_state;
  logic               r_mode;
  logic [WIDTH-1:0]   r_limit;
  logic [STEPS_W-1:0] r_steps;
  logic               r_done;
  logic               w_load;
  logic               w_step;

  // abort suppresses the datapath action of the aborting cycle so count holds
  assign w_load = (r_state == ST_LOAD) && !abort;
  assign w_step = (r_state == ST_RUN)  && !abort;

  updn_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .clr   (clr),
    .load  (w_load),
    .step  (w_step),
    .mode  (r_mode),
    .limit (r_limit),
    .count (count),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_UP;
      r_limit <= '0;
      r_steps <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_mode  <= cmd_mode;
            r_limit <= cmd_limit;
            r_steps <= cmd_steps;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_steps == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else begin
            r_steps <= r_steps - STEPS_W'(1);
            if (r_steps == STEPS_W'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ready is gated by clr combinationally so no handshake is offered during reset
  assign cmd_ready = (r_state == ST_IDLE) && !clr;
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign done      = r_done;

endmodule

// File: tb/tb_updn_count_sequencer.sv
// Directed bench for updn_count_sequencer: per-cycle expectations are queued
// as commands are driven and compared on the falling edge after each clock.
module tb_updn_count_sequencer;
  import updn_ctrl_pkg::*;

  localparam int WIDTH   = 4;
  localparam int STEPS_W = 8;

  logic               clk       = 1'b0;
  logic               clr       = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_mode  = 1'b0;
  logic [WIDTH-1:0]   cmd_limit = '0;
  logic [STEPS_W-1:0] cmd_steps = '0;
  logic               abort     = 1'b0;
  logic               cmd_ready;
  logic [WIDTH-1:0]   count;
  logic               busy;
  logic               wrap;
  logic               done;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             done;
    logic             busy;
    logic             ready;
  } exp_t;

  exp_t             sb_q[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] m_count  = '0;

  updn_count_sequencer #(.WIDTH(WIDTH), .STEPS_W(STEPS_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_limit (cmd_limit),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input logic [WIDTH-1:0] c, input logic w, input logic d,
                              input logic b, input logic r);
    exp_t e;
    e.count = c;
    e.wrap  = w;
    e.done  = d;
    e.busy  = b;
    e.ready = r;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest queued expectation.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".count"}, 32'(count),     32'(e.count));
      chk({tag, ".wrap"},  32'(wrap),      32'(e.wrap));
      chk({tag, ".done"},  32'(done),      32'(e.done));
      chk({tag, ".busy"},  32'(busy),      32'(e.busy));
      chk({tag, ".ready"}, 32'(cmd_ready), 32'(e.ready));
    end
  endtask

  task automatic model_step(input logic mode, input logic [WIDTH-1:0] lim,
                            input logic [WIDTH-1:0] c_in,
                            output logic [WIDTH-1:0] c_out, output logic w);
    w = 1'b0;
    if (mode == MODE_UP) begin
      if (c_in == lim) begin
        c_out = '0;
        w     = 1'b1;
      end else begin
        c_out = WIDTH'(c_in + 1);
      end
    end else begin
      if (c_in == '0) begin
        c_out = lim;
        w     = 1'b1;
      end else begin
        c_out = WIDTH'(c_in - 1);
      end
    end
  endtask

  // abort_at: 0 = abort during LOAD (also held through the accepting IDLE edge),
  // k>0 = abort in the k-th RUN cycle. clr_at: clr in the k-th RUN cycle.
  // noise: keep offering a different command while the sequencer is busy.
  task automatic run_cmd(input string tag, input logic mode, input logic [WIDTH-1:0] lim,
                         input logic [STEPS_W-1:0] steps, input int abort_at,
                         input int clr_at, input bit noise, input bit abort_done);
    logic [WIDTH-1:0] nc;
    logic             w;
    logic             last;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_limit = lim;
    cmd_steps = steps;
    if (abort_at == 0) abort = 1'b1;
    expect_cycle(m_count, 1'b0, 1'b0, 1'b1, 1'b0);
    tick({tag, "/accept"});
    if (noise) begin
      cmd_mode  = ~mode;
      cmd_limit = 4'd7;
      cmd_steps = 8'd2;
    end else begin
      cmd_valid = 1'b0;
    end
    if (abort_at == 0) begin
      expect_cycle(m_count, 1'b0, 1'b0, 1'b0, 1'b1);
      tick({tag, "/abort_load"});
      abort     = 1'b0;
      cmd_valid = 1'b0;
      return;
    end
    m_count = (mode == MODE_UP) ? '0 : lim;
    expect_cycle(m_count, 1'b0, steps == '0, steps != '0, 1'b0);
    tick({tag, "/load"});
    for (int i = 1; i <= int'(steps); i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        expect_cycle(m_count, 1'b0, 1'b0, 1'b0, 1'b1);
        tick({tag, "/abort_run"});
        abort     = 1'b0;
        cmd_valid = 1'b0;
        return;
      end
      if (i == clr_at) begin
        clr     = 1'b1;
        m_count = '0;
        expect_cycle(m_count, 1'b0, 1'b0, 1'b0, 1'b0);
        tick({tag, "/clr_run"});
        clr = 1'b0;
        #1;
        chk({tag, "/ready_after_clr"}, 32'(cmd_ready), 32'd1);
        return;
      end
      model_step(mode, lim, m_count, nc, w);
      m_count = nc;
      last    = (i == int'(steps));
      expect_cycle(m_count, w, last, !last, 1'b0);
      tick($sformatf("%s/step%0d", tag, i));
    end
    if (abort_done) abort = 1'b1;
    expect_cycle(m_count, 1'b0, 1'b0, 1'b0, 1'b1);
    tick({tag, "/idle"});
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset: clr held for two edges, ready must stay low while clr is high
    tick("pre_reset");
    expect_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("reset");
    clr = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    expect_cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("post_reset");

    run_cmd("up_l10_s12", MODE_UP,   4'd10, 8'd12, -1, -1, 1'b0, 1'b0);
    chk("up_l10_s12/final", 32'(count), 32'd1);
    run_cmd("dn_l5_s7",   MODE_DOWN, 4'd5,  8'd7,  -1, -1, 1'b0, 1'b1);
    chk("dn_l5_s7/final", 32'(count), 32'd4);
    run_cmd("dn_l15_s0",  MODE_DOWN, 4'd15, 8'd0,  -1, -1, 1'b0, 1'b0);
    run_cmd("up_l0_s3",   MODE_UP,   4'd0,  8'd3,  -1, -1, 1'b0, 1'b0);
    run_cmd("abort_run",  MODE_UP,   4'd15, 8'd20,  4, -1, 1'b1, 1'b0);
    chk("abort_run/hold", 32'(count), 32'd3);
    run_cmd("abort_load", MODE_DOWN, 4'd9,  8'd5,   0, -1, 1'b0, 1'b0);
    chk("abort_load/hold", 32'(count), 32'd3);
    run_cmd("clr_mid",    MODE_UP,   4'd15, 8'd10, -1,  4, 1'b1, 1'b0);
    run_cmd("held_cmd",   MODE_DOWN, 4'd7,  8'd2,  -1, -1, 1'b0, 1'b0);
    chk("held_cmd/final", 32'(count), 32'd5);

    // clr overrides a handshake and abort in the same cycle
    cmd_valid = 1'b1;
    cmd_mode  = MODE_UP;
    cmd_limit = 4'd3;
    cmd_steps = 8'd1;
    abort     = 1'b1;
    clr       = 1'b1;
    m_count   = '0;
    expect_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick("clr_vs_cmd");
    clr       = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    expect_cycle('0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick("clr_vs_cmd/idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updn_count_sequencer.md
UPDN_COUNT_SEQUENCER -- requirements
Module: updn_count_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: counter and limit width in bits.
REQ-002 Parameter STEPS_W, default 8: width of the step-count field.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_mode  input  1  direction: 1 = up, 0 = down.
REQ-008 cmd_limit  input  WIDTH  modulus limit n; count range is 0..n.
REQ-009 cmd_steps  input  STEPS_W  number of counter updates to perform (0 allowed).
REQ-010 abort  input  1  terminate the current run.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 wrap  output  1  one-cycle pulse; high in the cycle after a step that wrapped.
REQ-014 done  output  1  one-cycle pulse; high when a run completes normally.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-016 cmd_ready SHALL be high only in IDLE; a handshake is cmd_valid && cmd_ready at a clock edge.
REQ-017 On a handshake, cmd_mode, cmd_limit and cmd_steps SHALL be captured, and the FSM SHALL go IDLE->LOAD.
REQ-018 While the FSM is not in IDLE, command inputs SHALL be ignored.
REQ-019 LOAD SHALL last one cycle and initialise count: up -> 0, down -> limit.
REQ-020 LOAD->RUN when steps != 0; LOAD->DONE when steps == 0.
REQ-021 Each RUN cycle SHALL perform one step and decrement the remaining-step counter.
REQ-022 Up step: if count == limit, count becomes 0 (wrap); otherwise count becomes count+1.
REQ-023 Down step: if count == 0, count becomes limit (wrap); otherwise count becomes count-1.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; limit = 2^WIDTH-1 gives a full-range counter.
REQ-025 limit == 0 SHALL hold count at 0, with wrap asserted on every step.
REQ-026 RUN->DONE on the edge that performs the final step.
REQ-027 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-028 done SHALL be high in the cycle following the (steps+1)-th edge after the accepting edge.
REQ-029 count SHALL hold its last value from DONE until the next LOAD.
REQ-030 abort in LOAD or RUN SHALL go to IDLE at that edge.
REQ-031 On abort: no further step is taken, done is not pulsed, and count holds its value.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 wrap SHALL be 0 outside the cycle after a wrapping step; done and wrap SHALL never be high outside their defined cycles.

Reset
REQ-034 clr high at a clock edge SHALL force: state IDLE, count 0, remaining steps 0, wrap 0, done 0, busy 0.
REQ-035 clr SHALL override both abort and a handshake in the same cycle.
REQ-036 While clr is high, cmd_ready SHALL be 0.
REQ-037 clr asserted mid-run SHALL discard the run with no done pulse.
REQ-038 count SHALL be 0 in the first cycle after clr deasserts.

Structure
REQ-039 A shared package updn_ctrl_pkg SHALL hold the FSM state enum and the constants MODE_UP = 1 and MODE_DOWN = 0.
REQ-040 The count/step datapath SHALL be a sub-module updn_counter_core with load, step, mode and limit inputs, and count and wrap outputs.
REQ-041 The FSM and step counter SHALL reside in updn_count_sequencer.

Verification
REQ-042 Up, limit 10, steps 12 -> count 0,1..10,0,1; final count 1; wrap exactly once; done 13 cycles after accept.
REQ-043 Down, limit 5, steps 7 -> count 5,4,3,2,1,0,5,4; final count 4; one wrap, after the 6th step.
REQ-044 Steps 0, down, limit 15 -> count 15 after LOAD; done in the next cycle; no wrap.
REQ-045 Up, limit 0, steps 3 -> count stays 0; wrap high for 3 consecutive cycles; done once.
REQ-046 Up, limit 15, steps 20, abort at the 4th RUN cycle -> count holds 3; no done; cmd_ready high the next cycle; a new command issued while busy is ignored.
REQ-047 clr mid-RUN, with cmd_valid held high -> count 0, state IDLE, no done; the held command is accepted on the first edge after clr deasserts.
